aes_round_ctrl: RTL and testbench

Iterative round sequencer for the AES-128 encryption datapath. Accepts a plaintext/key pair, drives the shared SubBytes/ShiftRows/MixColumns/AddRoundKey round hardware through 11 passes (initial key addition, 9 full rounds, final round), and supplies the pass flags and round keys. Captures the result and returns the ciphertext over a valid/ready handshake. Sits between the host-side request interface and the round datapath.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_key_step.sv | 29 ++
 rtl/aes_round_ctrl.sv | 143 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the iterative AES-128 round controller:
// round count, FSM state encoding, round constants and the forward S-box.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  // Entry 0 is unused; pass r (1..10) uses RCON[r] to derive its round key.
  localparam logic [7:0] RCON [0:NR] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 key-schedule step: derives the next round key from
// the current one and its round constant.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] w_cur [4];
  logic [31:0] w_nxt [4];
  logic [31:0] temp;

  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign w_cur[gi] = key_i[127-32*gi -: 32];
    assign key_o[127-32*gi -: 32] = w_nxt[gi];
  end

  // SubWord(RotWord(w3)) with the round constant folded into the top byte.
  assign temp = {sbox(w_cur[3][23:16]), sbox(w_cur[3][15:8]),
                 sbox(w_cur[3][7:0]),   sbox(w_cur[3][31:24])} ^ {rcon_i, 24'h000000};

  assign w_nxt[0] = w_cur[0] ^ temp;
  assign w_nxt[1] = w_cur[1] ^ w_nxt[0];
  assign w_nxt[2] = w_cur[2] ^ w_nxt[1];
  assign w_nxt[3] = w_cur[3] ^ w_nxt[2];

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: issues 11 datapath passes per block and
// returns the ciphertext on a valid/ready port. AES_ROUND_TIMEOUT_EN adds a per-pass watchdog.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_out,
  output logic         dp_valid,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_is_first,
  output logic         dp_is_last,
  output logic [3:0]   dp_round,
  input  logic         dp_ok,
  input  logic [127:0] dp_result,
  output logic         err
);

  state_e       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_next;
  logic [7:0]   rcon_next;
  logic         expire;

  assign rcon_next = (round_q < 4'(NR)) ? RCON[round_q + 4'd1] : 8'h00;

  aes_key_step u_key_step (
    .key_i  (key_q),
    .rcon_i (rcon_next),
    .key_o  (key_next)
  );

`ifdef AES_ROUND_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       err_q;

  // A dp_ok arriving on the expiry cycle takes priority over the abort.
  assign expire = (state_q == WAIT) && !dp_ok && (wait_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = wait_q;
    if (state_q == ISSUE) begin
      wait_d = 8'd0;
    end else if (state_q == WAIT) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= expire;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign expire         = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = plain_in;
          key_d   = key_in;
          round_d = 4'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (dp_ok) begin
          data_d = dp_result;
          if (round_q == 4'(NR)) begin
            state_d = DONE;
          end else begin
            key_d   = key_next;
            round_d = round_q + 4'd1;
            state_d = ISSUE;
          end
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    dp_valid    = (state_q == ISSUE);
    out_valid   = (state_q == DONE);
    cipher_out  = data_q;
    dp_state    = data_q;
    dp_key      = key_q;
    dp_round    = round_q;
    dp_is_first = (round_q == 4'd0);
    dp_is_last  = (round_q == 4'(NR));
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with a behavioural AES datapath of
// programmable latency and a FIPS-197 style reference cipher.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] plain_in, key_in, cipher_out, dp_state, dp_key, dp_result;
  logic         dp_valid, dp_is_first, dp_is_last, dp_ok, err;
  logic [3:0]   dp_round;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plain_in(plain_in), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .cipher_out(cipher_out), .dp_valid(dp_valid),
    .dp_state(dp_state), .dp_key(dp_key), .dp_is_first(dp_is_first),
    .dp_is_last(dp_is_last), .dp_round(dp_round), .dp_ok(dp_ok),
    .dp_result(dp_result), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference AES ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic first, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    if (first) return s ^ k;
    for (int i = 0; i < 16; i++) b[i] = SBOX[s[127-8*i -: 8]];
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s;
    s = p;
    for (int r = 0; r <= 10; r++) s = aes_round(s, round_key(k, r), r == 0, r == 10);
    return s;
  endfunction

  // ---------------- datapath model and pass monitor ----------------
  int           lat = 1;
  bit           stall = 1'b0;
  bit           spur_ok = 1'b0;
  logic [127:0] spur_res = '0;
  bit           model_ok = 1'b0;
  bit           pending = 1'b0;
  int           pend_cnt = 0;
  logic [127:0] model_res = '0;
  logic [127:0] cap_state, cap_key, cur_key;
  logic [3:0]   cap_round;
  int           exp_round = 0;
  int           acc_cyc = 0;

  assign dp_ok     = model_ok | spur_ok;
  assign dp_result = spur_ok ? spur_res : model_res;

  always @(negedge clk) begin
    model_ok = 1'b0;
    if (in_valid && in_ready && !rst) begin
      acc_cyc   = cyc;
      exp_round = 0;
      cur_key   = key_in;
    end
    if (pending) begin
      if (!in_ready) begin
        chk("hold_state", dp_state, cap_state);
        chk("hold_key", dp_key, cap_key);
        chk("hold_round", 128'(dp_round), 128'(cap_round));
      end
      pend_cnt--;
      if (pend_cnt == 0) begin
        model_ok = 1'b1;
        pending  = 1'b0;
      end
    end
    if (dp_valid) begin
      chk("one_outstanding", 128'(pending), 128'(0));
      chk("dp_round", 128'(dp_round), 128'(exp_round));
      if (exp_round <= 10) chk("dp_key", dp_key, round_key(cur_key, exp_round));
      chk("dp_is_first", 128'(dp_is_first), 128'(exp_round == 0));
      chk("dp_is_last", 128'(dp_is_last), 128'(exp_round == 10));
      if (cur_key == FIPS_KEY && exp_round == 1)
        chk("fips_pass1_key", dp_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      cap_state = dp_state;
      cap_key   = dp_key;
      cap_round = dp_round;
      model_res = aes_round(dp_state, dp_key, dp_is_first, dp_is_last);
      if (!stall) begin
        pending  = 1'b1;
        pend_cnt = lat;
      end
      exp_round++;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_dp_valid"}, 128'(dp_valid), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_cipher"}, cipher_out, 128'(0));
    chk({tag, "_dp_state"}, dp_state, 128'(0));
    chk({tag, "_dp_key"}, dp_key, 128'(0));
    chk({tag, "_dp_round"}, 128'(dp_round), 128'(0));
    chk({tag, "_first"}, 128'(dp_is_first), 128'(1));
    chk({tag, "_last"}, 128'(dp_is_last), 128'(0));
  endtask

  task automatic start_req(input logic [127:0] p, input logic [127:0] k);
    bit got = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; plain_in = p; key_in = k;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    chk("accept_seen", 128'(got), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    plain_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic finish_req(input string tag, input logic [127:0] exp_c, input int exp_lat,
                            input int hold, input bit spur_done);
    bit           seen = 1'b0;
    logic [127:0] snap;
    int           meas = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk({tag, "_out_valid_seen"}, 128'(seen), 128'(1));
    if (!seen) begin
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      return;
    end
    meas = cyc - acc_cyc;
    if (exp_lat >= 0) chk({tag, "_latency"}, 128'(meas), 128'(exp_lat));
    chk({tag, "_cipher"}, cipher_out, exp_c);
    chk({tag, "_err"}, 128'(err), 128'(0));
    snap = cipher_out;
    if (hold > 0) begin
      @(posedge clk); #1;
      in_valid = 1'b1; plain_in = ~exp_c; key_in = exp_c;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, "_bp_out_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_bp_in_ready"}, 128'(in_ready), 128'(0));
        chk({tag, "_bp_dp_valid"}, 128'(dp_valid), 128'(0));
        chk({tag, "_bp_cipher"}, cipher_out, snap);
      end
    end
    if (spur_done) begin
      @(posedge clk); #1;
      spur_res = {$urandom, $urandom, $urandom, $urandom};
      spur_ok  = 1'b1;
      @(posedge clk); #1 spur_ok = 1'b0;
      @(negedge clk);
      chk({tag, "_spur_done_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_spur_done_cipher"}, cipher_out, snap);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_post_out_valid"}, 128'(out_valid), 128'(0));
    $display("txn %s cipher=%h latency=%0d pass_latency=%0d", tag, snap, meas, lat);
  endtask

  task automatic wait_model_idle();
    for (int i = 0; i < 50 && pending; i++) @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [127:0] p;
    logic [127:0] k;
    logic [127:0] c;
    int           l;
    int           hold;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [127:0] p, k, snap_state, snap_key;
    logic [3:0]   snap_round;
    bit           found;

    // Pass latency 2 gives three cycles per pass: 11*3+1 = 34 cycles accept->out_valid.
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, FIPS_KEY,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2, 20};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 1, 0};
    vecs[2] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97, 3, 2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plain_in = '0; key_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    for (int i = 0; i < 3; i++) begin
      lat = vecs[i].l;
      start_req(vecs[i].p, vecs[i].k);
      finish_req($sformatf("vec%0d", i), vecs[i].c, 11 * (vecs[i].l + 1) + 1, vecs[i].hold, i == 1);
    end

    // Spurious dp_ok in IDLE must not load the bogus result.
    snap_state = dp_state; snap_key = dp_key; snap_round = dp_round;
    @(posedge clk); #1;
    spur_res = ~snap_state;
    spur_ok  = 1'b1;
    @(posedge clk); #1 spur_ok = 1'b0;
    @(negedge clk);
    chk("idle_spur_in_ready", 128'(in_ready), 128'(1));
    chk("idle_spur_dp_valid", 128'(dp_valid), 128'(0));
    chk("idle_spur_state", dp_state, snap_state);
    chk("idle_spur_key", dp_key, snap_key);
    chk("idle_spur_round", 128'(dp_round), 128'(snap_round));

    for (int i = 0; i < 6; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      lat = int'($urandom_range(1, 4));
      start_req(p, k);
      finish_req($sformatf("rand%0d", i), aes_encrypt(p, k), 11 * (lat + 1) + 1,
                 int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset while waiting on pass 5; the late dp_ok must be ignored.
    lat = 4;
    p = {$urandom, $urandom, $urandom, $urandom};
    start_req(p, FIPS_KEY);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dp_valid && dp_round == 4'd5) found = 1'b1;
    end
    chk("rst_round5_seen", 128'(found), 128'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("late_ok_in_ready", 128'(in_ready), 128'(1));
      chk("late_ok_state", dp_state, 128'(0));
      chk("late_ok_round", 128'(dp_round), 128'(0));
    end
    $display("txn midrst aborted at pass 5");
    wait_model_idle();
    lat = 1;
    start_req(vecs[0].p, vecs[0].k);
    finish_req("after_rst", vecs[0].c, 23, 0, 1'b0);

`ifdef AES_ROUND_TIMEOUT_EN
    // Stalled datapath: err one cycle after the 64th WAIT cycle.
    stall = 1'b1;
    start_req(vecs[1].p, vecs[1].k);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dp_valid) found = 1'b1;
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("to_wait_err", 128'(err), 128'(0));
      chk("to_wait_in_ready", 128'(in_ready), 128'(0));
    end
    @(negedge clk);
    chk("to_err_pulse", 128'(err), 128'(1));
    chk("to_idle", 128'(in_ready), 128'(1));
    chk("to_no_out", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("to_err_one_cycle", 128'(err), 128'(0));
    $display("txn timeout abort err pulse observed");

    // dp_ok on the expiry cycle wins.
    start_req(vecs[1].p, vecs[1].k);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dp_valid) found = 1'b1;
    end
    repeat (63) @(negedge clk);
    @(posedge clk); #1;
    spur_res = model_res;
    spur_ok  = 1'b1;
    @(posedge clk); #1;
    spur_ok = 1'b0;
    stall   = 1'b0;
    @(negedge clk);
    chk("to_race_err", 128'(err), 128'(0));
    chk("to_race_next_issue", 128'(dp_valid), 128'(1));
    finish_req("to_race", vecs[1].c, -1, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
